// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared types and constants for the register-file write path.
//                Defines the address/data widths, the writeback-source code
//                reported on last_src, the hard-wired zero register and the
//                width of the starvation counter.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int REG_DATA_W   = 32;

  // Width of the starvation counter; limits up to 15 are representable.
  localparam int STARVE_CNT_W = 4;

  // Source of the write currently presented to the register file.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_MEM  = 2'd1,
    WB_ALU  = 2'd2
  } wb_src_t;

  // Register 0 reads as zero; writes to it are accepted and discarded.
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // True when a write to this address must actually reach the array.
  function automatic logic is_committable(input logic [REG_ADDR_W-1:0] addr);
    return (addr != ZERO_REG);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
//  Module      : starve_counter
//  Description : Saturating starvation counter for arbiters. Counts cycles in
//                which a requester is refused, stops at LIMIT and flags
//                at_limit so the arbiter can force a grant.
//  Ports       : clk      in   clock, rising-edge state updates
//                rst_n    in   asynchronous active-low reset
//                inc      in   requester was refused this cycle
//                clear    in   requester was served or withdrew
//                limit    in   saturation value
//                at_limit out  counter equals limit (registered state)
//  Revision    : 1.0  initial release
// ============================================================================
module starve_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic             at_limit
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Clear wins over inc: a served requester is no longer starving even if
  // the caller happens to assert both in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != limit)) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == limit);

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Shares the register file's single write port between the
//                memory-load and ALU writeback paths. Loads win by default;
//                a starvation counter forces an ALU grant after STARVE_LIMIT
//                consecutive refused cycles. The winning write is registered
//                and presented for a whole cycle so the register file can
//                commit it on its falling-edge write.
//  Ports       : clk, rst_n                 clock / async active-low reset
//                mem_valid/rd/data, mem_ready  load writeback handshake
//                alu_valid/rd/data, alu_ready  ALU writeback handshake
//                rd, write_rd, writeEnable  registered register-file write
//                last_src                   source of current write (0/1/2)
//                write_count                committed non-zero writes, wraps
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 3   // legal 1..15
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_DATA_W-1:0] mem_data,
  output logic                  mem_ready,

  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [REG_DATA_W-1:0] alu_data,
  output logic                  alu_ready,

  output logic [REG_ADDR_W-1:0] rd,
  output logic [REG_DATA_W-1:0] write_rd,
  output logic                  writeEnable,
  output logic [1:0]            last_src,
  output logic [15:0]           write_count
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  // --------------------------------------------------------------------------
  // Grant logic
  // --------------------------------------------------------------------------
  logic force_alu;
  logic mem_xfer;
  logic alu_xfer;

  // Readies depend only on the valids and the registered starvation state,
  // never on either source's address or data.
  always_comb begin
    mem_ready = !force_alu;
    alu_ready = force_alu || !mem_valid;
  end

  // The ready equations already make the two grants mutually exclusive:
  // without force_alu, alu_ready needs mem_valid low; with it, mem_ready is 0.
  assign mem_xfer = mem_valid && mem_ready;
  assign alu_xfer = alu_valid && alu_ready;

  // --------------------------------------------------------------------------
  // ALU starvation tracking
  // --------------------------------------------------------------------------
  logic starve_inc;
  logic starve_clr;

  assign starve_inc = alu_valid && !alu_ready;
  // A withdrawn ALU request leaves no history behind.
  assign starve_clr = alu_xfer || !alu_valid;

  starve_counter #(
    .WIDTH    (STARVE_CNT_W)
  ) u_starve_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (starve_inc),
    .clear    (starve_clr),
    .limit    (LIMIT),
    .at_limit (force_alu)
  );

  // --------------------------------------------------------------------------
  // Output write register
  // --------------------------------------------------------------------------
  logic [REG_ADDR_W-1:0] rd_q,          rd_d;
  logic [REG_DATA_W-1:0] write_rd_q,    write_rd_d;
  logic                  write_en_q,    write_en_d;
  wb_src_t               last_src_q,    last_src_d;
  logic [15:0]           write_count_q, write_count_d;

  always_comb begin
    // Address and data hold when idle; only the strobe and source drop.
    rd_d          = rd_q;
    write_rd_d    = write_rd_q;
    write_en_d    = 1'b0;
    last_src_d    = WB_NONE;
    write_count_d = write_count_q;

    if (mem_xfer) begin
      rd_d       = mem_rd;
      write_rd_d = mem_data;
      write_en_d = is_committable(mem_rd);
      last_src_d = WB_MEM;
    end else if (alu_xfer) begin
      rd_d       = alu_rd;
      write_rd_d = alu_data;
      write_en_d = is_committable(alu_rd);
      last_src_d = WB_ALU;
    end

    // Counts commits to the array, so register-0 writes are excluded.
    if (write_en_d) begin
      write_count_d = write_count_q + 16'd1;
    end
  end

  // Asynchronous reset drops an in-flight write immediately; the source has
  // to present it again after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q          <= ZERO_REG;
      write_rd_q    <= '0;
      write_en_q    <= 1'b0;
      last_src_q    <= WB_NONE;
      write_count_q <= '0;
    end else begin
      rd_q          <= rd_d;
      write_rd_q    <= write_rd_d;
      write_en_q    <= write_en_d;
      last_src_q    <= last_src_d;
      write_count_q <= write_count_d;
    end
  end

  assign rd          = rd_q;
  assign write_rd    = write_rd_q;
  assign writeEnable = write_en_q;
  assign last_src    = last_src_q;
  assign write_count = write_count_q;

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between the ALU writeback and memory-load writeback paths. Each source uses a valid/ready handshake. The block grants one source per cycle and registers the selected write. It drives the register file's `rd` / `write_rd` / `writeEnable` inputs one cycle after acceptance. Those inputs are stable across the register file's negative-edge write. Loads have priority, and a starvation counter guarantees ALU progress.

## Interface
- `STARVE_LIMIT`, default 3: number of consecutive cycles the ALU may be blocked before it is forcibly granted. Legal range is 1..15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  the load path has a write pending.
- `mem_rd`  in  5  destination register of the load.
- `mem_data`  in  32  load data.
- `mem_ready`  out  1  the load write is accepted this cycle.
- `alu_valid`  in  1  the ALU has a write pending.
- `alu_rd`  in  5  destination register of the ALU write.
- `alu_data`  in  32  ALU result.
- `alu_ready`  out  1  the ALU write is accepted this cycle.
- `rd`  out  5  register-file write address (registered).
- `write_rd`  out  32  register-file write data (registered).
- `writeEnable`  out  1  register-file write strobe (registered).
- `last_src`  out  2  source of the current output write: 0 none, 1 mem, 2 alu (registered).
- `write_count`  out  16  number of committed non-zero-register writes; wraps.

## Operation
- A transfer occurs when `valid && ready` for a source. At most one source transfers per cycle.
- `force_alu = (starve_cnt == STARVE_LIMIT)`.
- `mem_ready = !force_alu`.
- `alu_ready = force_alu || !mem_valid`.
- Ready outputs are combinational from the valids and `starve_cnt`. They never depend on their own source's data.
- Starvation counter `starve_cnt`, 4 bits:
  - Increments when `alu_valid && !alu_ready`.
  - Clears to 0 when the ALU transfers, or when `alu_valid` is low.
  - Saturates at `STARVE_LIMIT`.
- Output register update on each rising edge:
  - If a transfer occurs, `rd` and `write_rd` load the winner's address and data, and `last_src` loads the winner's code.
  - `writeEnable` is 1 if the winner's rd is non-zero, otherwise 0. Writes to register 0 are accepted but dropped.
  - If there is no transfer, `writeEnable` goes to 0 and `last_src` goes to 0. `rd` and `write_rd` hold their previous values.
- `write_count` increments by 1 (modulo 2^16) on each edge that loads `writeEnable` = 1.
- When both sources carry the same rd, the writes land in grant order, so the later grant's data persists.

## Timing
- Reset values: `rd` = 0, `write_rd` = 0, `writeEnable` = 0, `last_src` = 0, `write_count` = 0, `starve_cnt` = 0.
- During reset, `mem_ready` = 1 and `alu_ready` = !`mem_valid`. These are combinational, but no transfer is recorded while `rst_n` is low.
- Latency: a write accepted in cycle N appears on the outputs throughout cycle N+1. The register file commits it at the falling edge inside cycle N+1.
- Throughput: one write per cycle, sustained.
- Reset asserted mid-operation: the pending output write is cleared immediately, `writeEnable` = 0, and the write is lost. Sources must re-present it.
- With mem continuously valid and the ALU continuously valid, the grant pattern is mem ×STARVE_LIMIT, then alu ×1, repeating.
- A source may drop `valid` without a transfer; no state is retained for it.

## Structure
- Shared package `regfile_pkg`:
  - `REG_ADDR_W` = 5 and `REG_DATA_W` = 32.
  - Enum `wb_src_t` with values `WB_NONE`=0, `WB_MEM`=1, `WB_ALU`=2.
  - Constant `ZERO_REG` = 5'd0.
- One sub-module, `starve_counter`: a saturating counter with inc/clear/limit inputs and a `at_limit` output. It is reusable for other arbiters.
- Grant logic, output registers and `write_count` stay in the top level.

## Test plan
- Reset, then an ALU-only write with `alu_rd`=5, `alu_data`=0xDEADBEEF:
  - `alu_ready`=1 in the same cycle.
  - Next cycle: `rd`=5, `write_rd`=0xDEADBEEF, `writeEnable`=1, `last_src`=2.
  - `write_count`=1.
- Both sources valid for one cycle (mem rd=3, data 0x11; alu rd=4, data 0x22):
  - mem is written first.
  - The ALU is granted the following cycle.
  - Outputs show rd=3, then rd=4.
- Mem held valid continuously, ALU held valid for 8 cycles, `STARVE_LIMIT`=3:
  - Grants are mem, mem, mem, alu, mem, mem, mem, alu.
  - `alu_ready` is high only in cycles 4 and 8.
- Write to register 0 with data 0xFFFFFFFF:
  - The handshake completes.
  - `writeEnable`=0, `last_src`=1 or 2, and `write_count` is unchanged.
- `rst_n` dropped while `writeEnable`=1:
  - All outputs go to their reset values asynchronously, before the next clock edge.
  - After release, writes resume with `write_count`=0.
- 65537 back-to-back valid writes to rd=1:
  - `write_count` wraps to 1.
